// File: rtl/health_pkg.sv
// Shared types and constants for the player health controller and the
// health-bar renderer thresholds.
package health_pkg;

   localparam int unsigned HEALTH_W       = 4;
   localparam int unsigned DEF_MAX_HEALTH = 3;

   typedef enum logic [1:0] {
      ALIVE,
      IFRAME,
      DEAD
   } state_t;

   // Counter width for a count of n frame ticks, never narrower than 1 bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/frame_countdown.sv
// Loadable down-counter advanced by frame ticks; saturates at zero and
// reports it through a zero flag.
module frame_countdown
   import health_pkg::*;
#(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             load,
   input  logic             dec,
   input  logic [WIDTH-1:0] load_val,
   output logic             zero
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/health_controller.sv
// Player health register with damage/heal arbitration, frame-counted
// invulnerability with bar blinking, and game-over detection.
module health_controller
   import health_pkg::*;
#(
   parameter int unsigned MAX_HEALTH   = DEF_MAX_HEALTH,
   parameter int unsigned INIT_HEALTH  = 3,
   parameter int unsigned IFRAME_TICKS = 60,
   parameter int unsigned BLINK_PERIOD = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                frame_tick,
   input  logic                hit,
   input  logic                heal,
   input  logic                restart,
   output logic [HEALTH_W-1:0] present_health,
   output logic                invincible,
   output logic                health_visible,
   output logic                game_over,
   output logic                hit_accepted
);

   localparam int unsigned IF_W = cnt_width(IFRAME_TICKS);
   localparam int unsigned BL_W = cnt_width(BLINK_PERIOD);

   state_t              state_q, state_d;
   logic [HEALTH_W-1:0] health_q, health_d;
   logic                visible_q, visible_d;
   logic                hit_acc_q, hit_acc_d;

   logic cnt_clr;
   logic if_load, if_dec, if_zero;
   logic bl_load, bl_dec, bl_zero;

   frame_countdown #(.WIDTH(IF_W)) u_iframe_cnt (
      .clk      (clk),
      .rst_n    (rst),
      .clr      (cnt_clr),
      .load     (if_load),
      .dec      (if_dec),
      .load_val (IF_W'(IFRAME_TICKS - 1)),
      .zero     (if_zero)
   );

   frame_countdown #(.WIDTH(BL_W)) u_blink_cnt (
      .clk      (clk),
      .rst_n    (rst),
      .clr      (cnt_clr),
      .load     (bl_load),
      .dec      (bl_dec),
      .load_val (BL_W'(BLINK_PERIOD - 1)),
      .zero     (bl_zero)
   );

   always_comb begin
      state_d   = state_q;
      health_d  = health_q;
      visible_d = visible_q;
      hit_acc_d = 1'b0;
      cnt_clr   = 1'b0;
      if_load   = 1'b0;
      if_dec    = 1'b0;
      bl_load   = 1'b0;
      bl_dec    = 1'b0;

      if (restart) begin
         state_d   = ALIVE;
         health_d  = HEALTH_W'(INIT_HEALTH);
         visible_d = 1'b1;
         cnt_clr   = 1'b1;
      end else begin
         unique case (state_q)
            ALIVE: begin
               // frame_tick is deliberately not looked at here, so a tick
               // coinciding with the hit does not shorten the new window.
               if (hit && (health_q != '0)) begin
                  health_d  = health_q - HEALTH_W'(1);
                  hit_acc_d = 1'b1;
                  if (health_q == HEALTH_W'(1)) begin
                     state_d = DEAD;
                  end else begin
                     state_d   = IFRAME;
                     if_load   = 1'b1;
                     bl_load   = 1'b1;
                     visible_d = 1'b0;
                  end
               end else if (heal && (health_q < HEALTH_W'(MAX_HEALTH))) begin
                  health_d = health_q + HEALTH_W'(1);
               end
            end
            IFRAME: begin
               if (heal && (health_q < HEALTH_W'(MAX_HEALTH))) begin
                  health_d = health_q + HEALTH_W'(1);
               end
               if (frame_tick) begin
                  if (if_zero) begin
                     state_d   = ALIVE;
                     visible_d = 1'b1;
                  end else begin
                     if_dec = 1'b1;
                     if (bl_zero) begin
                        bl_load   = 1'b1;
                        visible_d = ~visible_q;
                     end else begin
                        bl_dec = 1'b1;
                     end
                  end
               end
            end
            DEAD: begin
               health_d  = '0;
               visible_d = 1'b1;
            end
            default: begin
               state_d = ALIVE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ALIVE;
         health_q  <= HEALTH_W'(INIT_HEALTH);
         visible_q <= 1'b1;
         hit_acc_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         health_q  <= health_d;
         visible_q <= visible_d;
         hit_acc_q <= hit_acc_d;
      end
   end

   assign present_health = health_q;
   assign invincible     = (state_q == IFRAME);
   assign game_over      = (state_q == DEAD);
   assign health_visible = visible_q;
   assign hit_accepted   = hit_acc_q;

endmodule

// File: tb/tb_health_controller.sv
// Table-driven bench for health_controller: per-cycle vectors feed a
// scoreboard queue that is drained one cycle later against the outputs.
module tb_health_controller;
   import health_pkg::*;

   typedef struct {
      logic [3:0] in_bits;   // {restart, hit, heal, frame_tick}
      logic [7:0] exp_bits;  // {health[3:0], invincible, visible, game_over, hit_accepted}
   } vec_t;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic                frame_tick = 1'b0;
   logic                hit = 1'b0;
   logic                heal = 1'b0;
   logic                restart = 1'b0;
   logic [HEALTH_W-1:0] present_health;
   logic                invincible;
   logic                health_visible;
   logic                game_over;
   logic                hit_accepted;

   int unsigned total = 0;
   int unsigned bad   = 0;

   vec_t       tbl[$];
   logic [7:0] expq[$];

   health_controller #(
      .MAX_HEALTH   (3),
      .INIT_HEALTH  (3),
      .IFRAME_TICKS (4),
      .BLINK_PERIOD (2)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .frame_tick     (frame_tick),
      .hit            (hit),
      .heal           (heal),
      .restart        (restart),
      .present_health (present_health),
      .invincible     (invincible),
      .health_visible (health_visible),
      .game_over      (game_over),
      .hit_accepted   (hit_accepted)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] outs();
      return {present_health, invincible, health_visible, game_over, hit_accepted};
   endfunction

   task automatic addv(input bit r, input bit h, input bit l, input bit t,
                       input int hp, input bit inv, input bit vis, input bit go,
                       input bit acc);
      vec_t v;
      v.in_bits  = {r, h, l, t};
      v.exp_bits = {4'(hp), inv, vis, go, acc};
      tbl.push_back(v);
   endtask

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got h=%0d inv=%b vis=%b go=%b acc=%b, want h=%0d inv=%b vis=%b go=%b acc=%b",
                  name, got[7:4], got[3], got[2], got[1], got[0],
                  want[7:4], want[3], want[2], want[1], want[0]);
      end
   endtask

   // Drive one cycle of stimulus just after a rising edge, queue its
   // expectation, then compare once the following edge has registered it.
   task automatic apply(input int idx, input vec_t v);
      logic [7:0] want;
      {restart, hit, heal, frame_tick} = v.in_bits;
      expq.push_back(v.exp_bits);
      @(posedge clk);
      #1;
      {restart, hit, heal, frame_tick} = 4'b0;
      if (expq.size() == 0) begin
         total++;
         bad++;
         $display("FAIL vec%0d: scoreboard empty", idx);
      end else begin
         want = expq.pop_front();
         check($sformatf("vec%0d", idx), outs(), want);
      end
   endtask

   initial begin
      //    r h l t  hp inv vis go acc
      addv(0,1,0,0, 2, 1, 0, 0, 1);  // hit at 3
      addv(0,0,0,0, 2, 1, 0, 0, 0);  // hit_accepted lasts one cycle
      addv(0,0,0,1, 2, 1, 0, 0, 0);  // tick 1
      addv(0,1,0,0, 2, 1, 0, 0, 0);  // hit ignored in IFRAME
      addv(0,0,0,1, 2, 1, 1, 0, 0);  // tick 2: blink toggle
      addv(0,0,0,1, 2, 1, 1, 0, 0);  // tick 3
      addv(0,0,0,1, 2, 0, 1, 0, 0);  // tick 4: back to ALIVE
      addv(0,1,1,0, 1, 1, 0, 0, 1);  // hit+heal: hit wins
      addv(0,0,1,0, 2, 1, 0, 0, 0);  // heal in IFRAME
      addv(0,0,0,1, 2, 1, 0, 0, 0);
      addv(0,0,0,1, 2, 1, 1, 0, 0);
      addv(0,0,0,1, 2, 1, 1, 0, 0);
      addv(0,0,0,1, 2, 0, 1, 0, 0);
      addv(0,0,1,0, 3, 0, 1, 0, 0);  // heal to max
      addv(0,0,1,0, 3, 0, 1, 0, 0);  // heal at max
      addv(0,1,0,0, 2, 1, 0, 0, 1);  // hit
      addv(0,0,1,0, 3, 1, 0, 0, 0);  // heal
      addv(0,0,1,0, 3, 1, 0, 0, 0);  // heal at max
      addv(0,0,0,1, 3, 1, 0, 0, 0);
      addv(0,0,0,1, 3, 1, 1, 0, 0);
      addv(0,0,0,1, 3, 1, 1, 0, 0);
      addv(0,0,0,1, 3, 0, 1, 0, 0);
      addv(0,1,0,1, 2, 1, 0, 0, 1);  // tick with hit does not count
      addv(0,0,0,1, 2, 1, 0, 0, 0);
      addv(0,0,0,1, 2, 1, 1, 0, 0);
      addv(0,0,0,1, 2, 1, 1, 0, 0);
      addv(0,0,0,1, 2, 0, 1, 0, 0);
      addv(0,1,0,0, 1, 1, 0, 0, 1);
      addv(0,0,0,1, 1, 1, 0, 0, 0);
      addv(0,0,0,1, 1, 1, 1, 0, 0);
      addv(0,0,0,1, 1, 1, 1, 0, 0);
      addv(0,0,0,1, 1, 0, 1, 0, 0);
      addv(0,1,0,0, 0, 0, 1, 1, 1);  // final hit: DEAD
      addv(0,1,0,0, 0, 0, 1, 1, 0);  // hit ignored when dead
      addv(0,0,1,0, 0, 0, 1, 1, 0);  // heal ignored when dead
      addv(0,1,1,1, 0, 0, 1, 1, 0);
      addv(1,1,0,0, 3, 0, 1, 0, 0);  // restart wins over hit in DEAD
      addv(0,0,1,0, 3, 0, 1, 0, 0);
      addv(0,1,0,0, 2, 1, 0, 0, 1);
      addv(1,0,0,0, 3, 0, 1, 0, 0);  // restart during IFRAME
      addv(0,1,0,0, 2, 1, 0, 0, 1);
      addv(0,0,0,1, 2, 1, 0, 0, 0);

      repeat (3) @(posedge clk);
      #1;
      check("reset_held", outs(), {4'd3, 1'b0, 1'b1, 1'b0, 1'b0});
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("reset_release", outs(), {4'd3, 1'b0, 1'b1, 1'b0, 1'b0});

      for (int i = 0; i < tbl.size(); i++) begin
         apply(i, tbl[i]);
      end

      // Mid-IFRAME asynchronous reset, observed well before the next edge.
      #2;
      rst = 1'b0;
      #1;
      check("async_reset", outs(), {4'd3, 1'b0, 1'b1, 1'b0, 1'b0});
      #2;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("post_reset_idle", outs(), {4'd3, 1'b0, 1'b1, 1'b0, 1'b0});
      begin
         vec_t v;
         v.in_bits  = 4'b0100;
         v.exp_bits = {4'd2, 1'b1, 1'b0, 1'b0, 1'b1};
         apply(1000, v);
      end

      if (expq.size() != 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", expq.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
